// File: rtl/stream_blur_pkg.sv
// Shared FSM state type and binomial kernel constants for the streaming blur.
package stream_blur_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // 1 2 1 / 2 4 2 / 1 2 1, sum 16
  localparam int K_CORNER        = 1;
  localparam int K_EDGE          = 2;
  localparam int K_CENTER        = 4;
  localparam int WEIGHT_SUM_LOG2 = 4;
  localparam int ROUND_HALF      = 1 << (WEIGHT_SUM_LOG2 - 1);

endpackage

// File: rtl/stream_blur_line_buffer.sv
// One-line pixel delay: the output is the pixel written DEPTH enabled steps ago.
module stream_blur_line_buffer #(
  parameter int DEPTH = 320,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Storage is deliberately unreset; border taps are masked by position counters.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  assign o_dout = r_mem[r_ptr];

endmodule

// File: rtl/stream_blur_filter.sv
// Streaming 3x3 binomial blur on an Avalon-ST video path with zero-padded borders,
// frame-locked blur/bypass mode and an end-of-frame flush.
//
// state | meaning
// IDLE  | wait for SOP; non-SOP beats are accepted and dropped
// FILL  | accept the first W+1 pixels of the frame, no output yet
// RUN   | each accepted pixel produces one output beat
// FLUSH | feed W+1 zero pixels internally to emit the frame tail
module stream_blur_filter
  import stream_blur_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int BPC        = 4,
  parameter int NCH        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               blur_en,
  input  logic               valid_in,
  input  logic               startofpacket_in,
  input  logic               endofpacket_in,
  input  logic [NCH*BPC-1:0] data_in,
  output logic               ready_out,
  input  logic               ready_in,
  output logic               valid_out,
  output logic               startofpacket_out,
  output logic               endofpacket_out,
  output logic [NCH*BPC-1:0] data_out
);

  localparam int DW    = NCH * BPC;
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = $clog2(NPIX + IMG_WIDTH + 1);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam int ACC_W = BPC + WEIGHT_SUM_LOG2;

  localparam logic [CNT_W-1:0] C_FILL_LAST  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] C_RUN_LAST   = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] C_FLUSH_LAST = CNT_W'(NPIX + IMG_WIDTH);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_in_cnt;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_blur_en;

  logic w_adv, w_step, w_restart, w_emit, w_flush;
  logic w_unused_eop;

  logic [DW-1:0] w_pix, w_lb1, w_lb2;
  logic [DW-1:0] r_l_top, r_l_mid, r_l_bot, r_m_top, r_m_mid, r_m_bot;
  logic [DW-1:0] w_tl, w_tc, w_tr, w_ml, w_mr, w_bl, w_bc, w_br;
  logic [DW-1:0] w_blur;
  logic          w_top_ok, w_bot_ok, w_left_ok, w_right_ok;
  logic          w_first, w_last;

  // Frame end comes from the pixel counter, so the input EOP carries no control.
  assign w_unused_eop = endofpacket_in;

  assign w_adv = !valid_out || ready_in;

  always_comb begin
    w_state_nxt = r_state;
    ready_out   = 1'b0;
    w_step      = 1'b0;
    w_restart   = 1'b0;
    w_emit      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_out = 1'b1;
        if (valid_in && startofpacket_in) begin
          w_restart   = 1'b1;
          w_step      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL, ST_RUN: begin
        ready_out = w_adv;
        if (valid_in && w_adv) begin
          w_step = 1'b1;
          if (startofpacket_in) begin
            w_restart   = 1'b1;
            w_state_nxt = ST_FILL;
          end else if (r_state == ST_FILL) begin
            if (r_in_cnt == C_FILL_LAST) w_state_nxt = ST_RUN;
          end else begin
            w_emit = 1'b1;
            if (r_in_cnt == C_RUN_LAST) w_state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (w_adv) begin
          w_step  = 1'b1;
          w_flush = 1'b1;
          w_emit  = 1'b1;
          if (r_in_cnt == C_FLUSH_LAST) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_row/r_col track the centre pixel of the next output beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_cnt  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_blur_en <= 1'b0;
    end else begin
      if (w_restart) begin
        r_in_cnt  <= CNT_W'(1);
        r_row     <= '0;
        r_col     <= '0;
        r_blur_en <= blur_en;
      end else if (w_step) begin
        r_in_cnt <= r_in_cnt + 1'b1;
      end
      if (w_emit) begin
        if (r_col == COL_W'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign w_pix = w_flush ? '0 : data_in;

  stream_blur_line_buffer #(.DEPTH(IMG_WIDTH), .DW(DW)) u_lb1 (
    .clk(clk), .rst(reset), .i_en(w_step), .i_din(w_pix), .o_dout(w_lb1)
  );

  stream_blur_line_buffer #(.DEPTH(IMG_WIDTH), .DW(DW)) u_lb2 (
    .clk(clk), .rst(reset), .i_en(w_step), .i_din(w_lb1), .o_dout(w_lb2)
  );

  // Right column is live (incoming pixel and buffer outputs); middle/left are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l_top <= '0; r_l_mid <= '0; r_l_bot <= '0;
      r_m_top <= '0; r_m_mid <= '0; r_m_bot <= '0;
    end else if (w_step) begin
      r_l_top <= r_m_top; r_l_mid <= r_m_mid; r_l_bot <= r_m_bot;
      r_m_top <= w_lb2;   r_m_mid <= w_lb1;   r_m_bot <= w_pix;
    end
  end

  assign w_top_ok   = (r_row != '0);
  assign w_bot_ok   = (r_row != ROW_W'(IMG_HEIGHT - 1));
  assign w_left_ok  = (r_col != '0);
  assign w_right_ok = (r_col != COL_W'(IMG_WIDTH - 1));

  assign w_tl = (w_top_ok && w_left_ok)  ? r_l_top : '0;
  assign w_tc = w_top_ok                 ? r_m_top : '0;
  assign w_tr = (w_top_ok && w_right_ok) ? w_lb2   : '0;
  assign w_ml = w_left_ok                ? r_l_mid : '0;
  assign w_mr = w_right_ok               ? w_lb1   : '0;
  assign w_bl = (w_bot_ok && w_left_ok)  ? r_l_bot : '0;
  assign w_bc = w_bot_ok                 ? r_m_bot : '0;
  assign w_br = (w_bot_ok && w_right_ok) ? w_pix   : '0;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    localparam int LO = (NCH - 1 - ch) * BPC;
    logic [ACC_W-1:0] w_corner, w_edge, w_acc;

    assign w_corner = ACC_W'(w_tl[LO +: BPC]) + ACC_W'(w_tr[LO +: BPC])
                    + ACC_W'(w_bl[LO +: BPC]) + ACC_W'(w_br[LO +: BPC]);
    assign w_edge   = ACC_W'(w_tc[LO +: BPC]) + ACC_W'(w_ml[LO +: BPC])
                    + ACC_W'(w_mr[LO +: BPC]) + ACC_W'(w_bc[LO +: BPC]);
    assign w_acc    = w_corner * ACC_W'(K_CORNER) + w_edge * ACC_W'(K_EDGE)
                    + ACC_W'(r_m_mid[LO +: BPC]) * ACC_W'(K_CENTER) + ACC_W'(ROUND_HALF);
    assign w_blur[LO +: BPC] = BPC'(w_acc >> WEIGHT_SUM_LOG2);
  end

  assign w_first = (r_row == '0) && (r_col == '0);
  assign w_last  = (r_row == ROW_W'(IMG_HEIGHT - 1)) && (r_col == COL_W'(IMG_WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out         <= 1'b0;
      startofpacket_out <= 1'b0;
      endofpacket_out   <= 1'b0;
      data_out          <= '0;
    end else if (w_adv) begin
      valid_out <= w_emit;
      if (w_emit) begin
        data_out          <= r_blur_en ? w_blur : r_m_mid;
        startofpacket_out <= w_first;
        endofpacket_out   <= w_last;
      end else begin
        startofpacket_out <= 1'b0;
        endofpacket_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_blur_filter.sv
// Self-checking bench for stream_blur_filter at W=4, H=3: randomized frames and stalls
// scored against a direct 2-D convolution model of the frame.
module tb_stream_blur_filter;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int BPC  = 4;
  localparam int NCH  = 3;
  localparam int DW   = NCH * BPC;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          blur_en, valid_in, startofpacket_in, endofpacket_in;
  logic [DW-1:0] data_in;
  logic          ready_out, ready_in;
  logic          valid_out, startofpacket_out, endofpacket_out;
  logic [DW-1:0] data_out;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [DW-1:0] frm [NPIX];
  beat_t         want_q [$];
  logic [DW-1:0] cap [$];
  bit            mon_en = 1'b0;
  bit            stall_mode = 1'b0;
  bit            cnt_en = 1'b0;
  int            nrdy0 = 0;
  int            first_v_cyc = -1;
  int            acc5_cyc = -2;

  stream_blur_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BPC(BPC), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .blur_en(blur_en), .valid_in(valid_in),
    .startofpacket_in(startofpacket_in), .endofpacket_in(endofpacket_in),
    .data_in(data_in), .ready_out(ready_out), .ready_in(ready_in),
    .valid_out(valid_out), .startofpacket_out(startofpacket_out),
    .endofpacket_out(endofpacket_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Zero-padded 3x3 binomial convolution of frm, or the raw pixel in bypass.
  function automatic logic [DW-1:0] ref_pix(input int k, input bit blur);
    logic [DW-1:0] res;
    int r, c, rr, cc, sum, chv, sh;
    r = k / W;
    c = k % W;
    if (!blur) return frm[k];
    res = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      sh  = (NCH - 1 - ch) * BPC;
      sum = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          rr = r + dr;
          cc = c + dc;
          if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
            chv = (int'(frm[rr*W+cc]) >> sh) % (1 << BPC);
            sum += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * chv;
          end
        end
      end
      res = res | (DW'((sum + 8) / 16) << sh);
    end
    return res;
  endfunction

  task automatic push_want(input int nout, input bit mode, input bit full);
    beat_t b;
    for (int k = 0; k < nout; k++) begin
      b.d   = ref_pix(k, mode);
      b.sop = (k == 0);
      b.eop = full && (k == NPIX - 1);
      want_q.push_back(b);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NPIX; i++) frm[i] = DW'($urandom);
  endtask

  // Sends frm[0..npx-1]; blur_en flips to !mode from pixel 6 when toggle is set.
  task automatic send_frame(input int npx, input bit mode, input bit toggle, input int gap);
    int waited;
    for (int i = 0; i < npx; i++) begin
      while ($urandom_range(0, 99) < gap) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      valid_in         = 1'b1;
      data_in          = frm[i];
      startofpacket_in = (i == 0);
      endofpacket_in   = (i == NPIX - 1);
      blur_en          = (toggle && i >= 6) ? !mode : mode;
      waited = 0;
      forever begin
        @(negedge clk);
        if (ready_out || waited > 300) break;
        waited++;
      end
      if (waited > 300) begin
        chk("accept_timeout", 32'(waited), 0);
        break;
      end
      if (i == 5) acc5_cyc = cyc + 1;
      @(posedge clk); #1;
    end
    valid_in         = 1'b0;
    startofpacket_in = 1'b0;
    endofpacket_in   = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (want_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(want_q.size()), 0);
    want_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready_in = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  initial begin : monitor
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_sop, prev_eop;
    beat_t         b;
    forever begin
      @(negedge clk);
      if (mon_en && prev_stall) begin
        chk("stall_valid", 32'(valid_out), 1);
        chk("stall_data", 32'(data_out), 32'(prev_d));
        chk("stall_sop", 32'(startofpacket_out), 32'(prev_sop));
        chk("stall_eop", 32'(endofpacket_out), 32'(prev_eop));
      end
      prev_stall = mon_en && valid_out && !ready_in;
      prev_d     = data_out;
      prev_sop   = startofpacket_out;
      prev_eop   = endofpacket_out;
      if (mon_en && valid_out && ready_in) begin
        chk("beat_expected", 32'(want_q.size() > 0), 1);
        if (want_q.size() > 0) begin
          b = want_q.pop_front();
          chk("beat_data", 32'(data_out), 32'(b.d));
          chk("beat_sop", 32'(startofpacket_out), 32'(b.sop));
          chk("beat_eop", 32'(endofpacket_out), 32'(b.eop));
        end
        cap.push_back(data_out);
      end
      if (first_v_cyc < 0 && valid_out) first_v_cyc = cyc;
      if (cnt_en && !ready_out) nrdy0++;
    end
  end

  initial begin
    bit m;
    reset = 1'b1;
    blur_en = 1'b0; valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_sop", 32'(startofpacket_out), 0);
    chk("rst_eop", 32'(endofpacket_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_ready", 32'(ready_out), 1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Bypass ramp: latency, framing and flush duration.
    for (int i = 0; i < NPIX; i++) frm[i] = DW'(i);
    push_want(NPIX, 1'b0, 1'b1);
    cap.delete();
    nrdy0 = 0; first_v_cyc = -1; cnt_en = 1'b1;
    send_frame(NPIX, 1'b0, 1'b0, 0);
    wait_drain();
    cnt_en = 1'b0;
    chk("byp_count", 32'(cap.size()), NPIX);
    chk("byp_flush_cycles", 32'(nrdy0), W + 1);
    chk("byp_latency", 32'(first_v_cyc), 32'(acc5_cyc));

    // Blur of a flat white frame: corner, edge and interior values.
    for (int i = 0; i < NPIX; i++) frm[i] = 12'hFFF;
    push_want(NPIX, 1'b1, 1'b1);
    cap.delete();
    send_frame(NPIX, 1'b1, 1'b0, 0);
    wait_drain();
    if (cap.size() == NPIX) begin
      chk("white_corner", 32'(cap[0]), 32'h888);
      chk("white_edge", 32'(cap[1]), 32'hBBB);
      chk("white_int11", 32'(cap[5]), 32'hFFF);
      chk("white_int12", 32'(cap[6]), 32'hFFF);
    end else begin
      chk("white_count", 32'(cap.size()), NPIX);
    end

    // Single red impulse at (1,1).
    for (int i = 0; i < NPIX; i++) frm[i] = '0;
    frm[5] = 12'hF00;
    push_want(NPIX, 1'b1, 1'b1);
    cap.delete();
    send_frame(NPIX, 1'b1, 1'b0, 0);
    wait_drain();
    if (cap.size() == NPIX) begin
      chk("imp_centre", 32'(cap[5]), 32'h400);
      chk("imp_edge", 32'(cap[1]), 32'h200);
      chk("imp_corner", 32'(cap[0]), 32'h100);
    end else begin
      chk("imp_count", 32'(cap.size()), NPIX);
    end

    // Random frames, back to back, with downstream stalls and upstream gaps.
    stall_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      rand_frame();
      m = 1'($urandom);
      push_want(NPIX, m, 1'b1);
      send_frame(NPIX, m, 1'b0, 20);
    end
    wait_drain();

    // Frame aborted by SOP at input pixel 7, then a full frame.
    rand_frame();
    m = 1'($urandom);
    push_want(7 - W - 1, m, 1'b0);
    send_frame(7, m, 1'b0, 10);
    rand_frame();
    push_want(NPIX, !m, 1'b1);
    send_frame(NPIX, !m, 1'b0, 10);
    wait_drain();

    // blur_en flipped mid-frame only takes effect on the next SOP.
    rand_frame();
    push_want(NPIX, 1'b1, 1'b1);
    send_frame(NPIX, 1'b1, 1'b1, 10);
    rand_frame();
    push_want(NPIX, 1'b0, 1'b1);
    send_frame(NPIX, 1'b0, 1'b1, 10);
    wait_drain();

    // Reset asserted mid-RUN, then dropped non-SOP beats, then a clean frame.
    stall_mode = 1'b0;
    repeat (2) @(posedge clk); #1;
    mon_en = 1'b0;
    rand_frame();
    send_frame(8, 1'b1, 1'b0, 0);
    chk("pre_rst_valid", 32'(valid_out), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid_out), 0);
    chk("mid_rst_sop", 32'(startofpacket_out), 0);
    chk("mid_rst_data", 32'(data_out), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(ready_out), 1);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = DW'($urandom);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    rand_frame();
    push_want(NPIX, 1'b1, 1'b1);
    send_frame(NPIX, 1'b1, 1'b0, 0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_blur_filter.md
Name: stream_blur_filter

Overview:
- Parametrised successor to the fixed 320-wide blur stage. A streaming 3x3 binomial blur on an Avalon-ST video path (ready latency 0), generic in image size, bits per channel and channel count.
- Adds proper backpressure, zero-padded borders, frame-locked mode selection and an end-of-frame flush, so the output frame has exactly IMG_WIDTH*IMG_HEIGHT beats with correct SOP/EOP.
- Sits between the camera/pixel source and the display/VGA sink, in place of the old blur stage.

Parameters:
- IMG_WIDTH, 320, pixels per line (>=2)
- IMG_HEIGHT, 240, lines per frame (>=2)
- BPC, 4, bits per colour channel
- NCH, 3, channels per pixel; channel 0 in the MSBs (red = data[11:8] at defaults)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- blur_en  in  1  1 = blur, 0 = bypass; sampled only on the accepted SOP beat
- valid_in  in  1  upstream data valid
- startofpacket_in  in  1  first pixel of frame
- endofpacket_in  in  1  last pixel of frame (informational, see Behaviour)
- data_in  in  NCH*BPC  input pixel
- ready_out  out  1  to upstream: beat accepted when valid_in && ready_out
- ready_in  in  1  from downstream sink
- valid_out  out  1  output valid
- startofpacket_out  out  1  first output pixel of frame
- endofpacket_out  out  1  last output pixel of frame
- data_out  out  NCH*BPC  output pixel

Behaviour:
- Reset (async, any state): state=IDLE; valid_out, startofpacket_out, endofpacket_out = 0; data_out = 0; counters = 0; mode latch = bypass. Line buffers are not reset.
- Window: two line buffers of IMG_WIDTH entries plus a 3x3 register window. The centre pixel (r,c) is computed when input pixel index (r*W+c)+W+1 is accepted.
- Zero padding: taps with r-1<0, r+1>=H, c-1<0 or c+1>=W are forced to 0. Masking is done by row/column counters, never by stale buffer contents.
- Weights: 1 2 1 / 2 4 2 / 1 2 1, sum 16.
  - Per-channel accumulator is BPC+4 bits.
  - Result = (acc+8)>>4, which fits BPC with no saturation.
- Bypass: data_out = raw centre pixel, with identical latency and beat timing.
- Output register: one stage. Advance condition adv = !valid_out || ready_in.
- States:
  - IDLE: ready_out=1. Non-SOP beats are accepted and dropped. An SOP beat latches blur_en, resets the in/out counters, stores pixel 0 and goes to FILL.
  - FILL: ready_out=adv. Accepts the first W+1 pixels without producing output, then goes to RUN.
  - RUN: ready_out=adv. Each accepted beat produces one output beat on the next cycle. When the accepted-pixel count reaches W*H, go to FLUSH.
  - FLUSH: ready_out=0. Feeds zero pixels internally and emits W+1 output beats, one per cycle while adv. After the last one, go to IDLE.
- Output framing:
  - startofpacket_out on output pixel 0, endofpacket_out on output pixel W*H-1, from the output counter.
  - Per frame: exactly W*H output beats.
- Latency: output pixel k appears one cycle after input pixel k+W+1 is accepted, or after flush step k-(W*H-W-1).
- endofpacket_in: ignored for control; the frame end comes from the counter. An early EOP has no effect. A missing EOP still completes the frame.
- SOP in FILL/RUN (aborted frame):
  - The accepted SOP beat restarts the frame: counters clear, the mode is re-latched and the state goes to FILL.
  - An output beat already in the register is held until taken, with EOP forced to 0.
  - The aborted frame emits no EOP.
- SOP during FLUSH is not accepted (ready_out=0) and is taken in IDLE.
- Downstream stall: while valid_out && !ready_in, all outputs are held stable and no state, counter or buffer advances.
- blur_en changes mid-frame have no effect until the next SOP.

Decomposition:
- Package stream_blur_pkg: state enum (IDLE, FILL, RUN, FLUSH), the kernel weight constants, and the WEIGHT_SUM_LOG2=4 constant.
- Sub-module stream_blur_line_buffer: a W-deep, NCH*BPC-wide shift/RAM line delay with an enable input. It is instantiated twice.
- Per-channel arithmetic uses a generate loop; no separate module.

Test Plan (W=4, H=3, BPC=4, NCH=3 unless stated):
- Bypass, ramp pixels 0..11, ready_in=1: 12 output beats equal to the inputs; first output one cycle after input 5; SOP on beat 0, EOP on beat 11; ready_out=0 for 5 FLUSH cycles.
- Blur, all pixels 0xFFF: interior (1,1),(1,2) = 0xFFF; corner (0,0) = (9*15+8)>>4 = 0x888 per channel; edge (0,1) = (12*15+8)>>4 = 0xBBB.
- Blur, single pixel 0xF00 at (1,1), rest 0: output (1,1)=0x400, (0,1)=0x200, (0,0)=0x100; green and blue = 0.
- Random ready_in stalls, 30% duty: output sequence matches the ready_in=1 run; data_out and valid_out stable during every stall.
- SOP re-asserted at input pixel 7, then a full frame: no EOP for the aborted frame; the next frame gives 12 correct beats.
- blur_en toggled mid-frame: the current frame keeps the mode latched at SOP; the next frame uses the new mode. Asserting reset mid-RUN: valid_out=0 in the same cycle and state=IDLE.
